rsa_exp_arbiter: RTL

Arbiter and sequencer that shares one modular-exponentiation core (`mod_exp`, modulus fixed by its parameters) between two requesting channels, for example an encrypt path (public exponent) and a decrypt path (private exponent). It accepts one request at a time with a round-robin tie-break and latches that request's exponent and message. It then launches the core, waits for completion under a watchdog, and returns the result or an error to the owning channel. It sits between the channel front-ends and the single core instance in the RSA top level.

---
 rtl/rsa_exp_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rsa_exp_arbiter.sv
// Two-channel arbiter/sequencer that time-shares a single mod_exp core.
// Accepts one request at a time (round-robin on ties), latches its operands,
// launches the core, waits under a watchdog and returns result or error to
// the owning channel.
module rsa_exp_arbiter #(
    parameter int unsigned K       = 7,
    parameter int unsigned EXP_W   = 7,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TO_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [EXP_W-1:0] exp0,
    input  logic [EXP_W-1:0] exp1,
    input  logic [K-1:0]     msg0,
    input  logic [K-1:0]     msg1,
    output logic             ack0,
    output logic             ack1,
    output logic             rdy0,
    output logic             rdy1,
    output logic [K-1:0]     res0,
    output logic [K-1:0]     res1,
    output logic             err0,
    output logic             err1,
    output logic             core_start,
    output logic [EXP_W-1:0] core_x,
    output logic [K-1:0]     core_y,
    input  logic [K-1:0]     core_z,
    input  logic             core_done,
    output logic             core_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DELIVER,
        S_ABORT
    } state_t;

    state_t           state_q;
    logic             lsp_q;
    logic             owner_q;
    logic             zero_q;
    logic [TO_W-1:0]  wd_q;
    logic [1:0]       ack_q;
    logic [1:0]       rdy_q;
    logic [1:0]       err_q;
    logic [K-1:0]     res0_q;
    logic [K-1:0]     res1_q;
    logic [EXP_W-1:0] core_x_q;
    logic [K-1:0]     core_y_q;
    logic             core_start_q;
    logic             core_clr_q;

    logic             sel_c;
    logic [1:0]       sel_mask_c;
    logic [1:0]       owner_mask_c;
    logic [EXP_W-1:0] sel_exp_c;
    logic [K-1:0]     sel_msg_c;
    logic [TO_W-1:0]  wd_inc_c;
    logic             timeout_c;

    // Winner selection (lone requester wins, tie goes to the channel not served last) and watchdog compare
    always_comb begin
        sel_c = req1;
        if (req0 && req1) begin
            sel_c = ~lsp_q;
        end
        sel_mask_c   = sel_c ? 2'b10 : 2'b01;
        owner_mask_c = owner_q ? 2'b10 : 2'b01;
        sel_exp_c    = sel_c ? exp1 : exp0;
        sel_msg_c    = sel_c ? msg1 : msg0;
        wd_inc_c     = wd_q + TO_W'(1);
        timeout_c    = (wd_inc_c == TO_W'(TIMEOUT));
    end

    // Sequencer FSM; every pulse output is cleared each cycle unless re-asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lsp_q        <= 1'b1;
            owner_q      <= 1'b0;
            zero_q       <= 1'b0;
            wd_q         <= '0;
            ack_q        <= '0;
            rdy_q        <= '0;
            err_q        <= '0;
            res0_q       <= '0;
            res1_q       <= '0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            core_start_q <= 1'b0;
            core_clr_q   <= 1'b0;
        end else begin
            ack_q        <= '0;
            rdy_q        <= '0;
            err_q        <= '0;
            core_start_q <= 1'b0;
            core_clr_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        ack_q    <= sel_mask_c;
                        owner_q  <= sel_c;
                        lsp_q    <= sel_c;
                        core_x_q <= sel_exp_c;
                        core_y_q <= sel_msg_c;
                        if (sel_exp_c == '0) begin
                            // x^0 = 1: skip the core entirely
                            zero_q  <= 1'b1;
                            state_q <= S_DELIVER;
                        end else begin
                            core_start_q <= 1'b1;
                            state_q      <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        rdy_q <= owner_mask_c;
                        if (owner_q) begin
                            res1_q <= core_z;
                        end else begin
                            res0_q <= core_z;
                        end
                        state_q <= S_DELIVER;
                    end else if (timeout_c) begin
                        rdy_q      <= owner_mask_c;
                        err_q      <= owner_mask_c;
                        core_clr_q <= 1'b1;
                        if (owner_q) begin
                            res1_q <= '0;
                        end else begin
                            res0_q <= '0;
                        end
                        state_q <= S_ABORT;
                    end else begin
                        wd_q <= wd_inc_c;
                    end
                end
                S_DELIVER: begin
                    if (zero_q) begin
                        // Zero-exponent result is presented in a second DELIVER cycle
                        zero_q <= 1'b0;
                        rdy_q  <= owner_mask_c;
                        if (owner_q) begin
                            res1_q <= K'(1);
                        end else begin
                            res0_q <= K'(1);
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ABORT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0       = ack_q[0];
    assign ack1       = ack_q[1];
    assign rdy0       = rdy_q[0];
    assign rdy1       = rdy_q[1];
    assign err0       = err_q[0];
    assign err1       = err_q[1];
    assign res0       = res0_q;
    assign res1       = res1_q;
    assign core_start = core_start_q;
    assign core_clr   = core_clr_q;
    assign core_x     = core_x_q;
    assign core_y     = core_y_q;

endmodule
